// File: rtl/step_sequencer.sv
// step_sequencer: run level and paced step-pulse source for the capture step limiter.
// Define STEP_SEQUENCER_TRIGGER_EN to add the i_trigger port and an ARMED stage before RUN.
module step_sequencer #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_single,
    input  logic                i_abort,
    input  logic                i_stop,
`ifdef STEP_SEQUENCER_TRIGGER_EN
    input  logic                i_trigger,
`endif
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_run,
    output logic                o_step,
    output logic                o_busy,
    output logic                o_done,
    output logic [COUNT_W-1:0]  o_step_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
`ifdef STEP_SEQUENCER_TRIGGER_EN
        , ST_ARMED = 3'd4
`endif
    } state_t;

    state_t                r_state;
    logic                  r_run;
    logic                  r_step;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ign_stop;
    logic [COUNT_W-1:0]    r_count;
    logic [PERIOD_W-1:0]   r_pre;
    logic [PERIOD_W-1:0]   r_period;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    // The step pulse is registered, so the prescaler runs one cycle ahead of o_step:
    // a launch evaluates prescaler value 0 in the launch cycle itself.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_run      <= 1'b0;
            r_step     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ign_stop <= 1'b0;
            r_count    <= COUNT_W'(0);
            r_pre      <= PERIOD_W'(0);
            r_period   <= PERIOD_W'(0);
        end else begin
            r_step <= 1'b0;
            if (i_abort) begin
                r_state    <= ST_IDLE;
                r_run      <= 1'b0;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_ign_stop <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (i_start) begin
                            r_period <= i_period;
                            r_count  <= COUNT_W'(0);
                            r_done   <= 1'b0;
                            r_busy   <= 1'b1;
`ifdef STEP_SEQUENCER_TRIGGER_EN
                            r_state  <= ST_ARMED;
                            r_pre    <= PERIOD_W'(0);
`else
                            r_state    <= ST_RUN;
                            r_run      <= 1'b1;
                            r_ign_stop <= 1'b1;
                            if (i_period == PERIOD_W'(0)) begin
                                r_step  <= 1'b1;
                                r_count <= COUNT_W'(1);
                                r_pre   <= PERIOD_W'(0);
                            end else begin
                                r_pre   <= PERIOD_W'(1);
                            end
`endif
                        end
                    end
`ifdef STEP_SEQUENCER_TRIGGER_EN
                    ST_ARMED: begin
                        if (i_trigger) begin
                            r_state    <= ST_RUN;
                            r_run      <= 1'b1;
                            r_ign_stop <= 1'b1;
                            if (r_period == PERIOD_W'(0)) begin
                                r_step  <= 1'b1;
                                r_count <= COUNT_W'(1);
                                r_pre   <= PERIOD_W'(0);
                            end else begin
                                r_pre   <= PERIOD_W'(1);
                            end
                        end
                    end
`endif
                    ST_RUN: begin
                        // The limiter's stop is stale during the first run cycle after a launch.
                        r_ign_stop <= 1'b0;
                        if (i_stop && !r_ign_stop) begin
                            r_state <= ST_DONE;
                            r_run   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (i_pause) begin
                            r_state <= ST_PAUSE;
                        end else if (r_pre == r_period) begin
                            r_step  <= 1'b1;
                            r_count <= sat_inc(r_count);
                            r_pre   <= PERIOD_W'(0);
                        end else begin
                            r_pre   <= r_pre + PERIOD_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (i_stop && !r_ign_stop) begin
                            r_state <= ST_DONE;
                            r_run   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (i_start) begin
                            r_state <= ST_RUN;
                        end else if (i_single) begin
                            r_step  <= 1'b1;
                            r_count <= sat_inc(r_count);
                        end else begin
                            r_state <= ST_PAUSE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_run        = r_run;
    assign o_step       = r_step;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_step_count = r_count;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a cycle-level reference model predicts every output vector.
module tb_step_sequencer;
    localparam int PW   = 16;
    localparam int CW   = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          tb_reset  = 1'b1;
    logic          tb_start  = 1'b0;
    logic          tb_pause  = 1'b0;
    logic          tb_single = 1'b0;
    logic          tb_abort  = 1'b0;
    logic          tb_stop   = 1'b0;
    logic          tb_trig   = 1'b0;
    logic [PW-1:0] tb_period = '0;

    logic          o_run, o_step, o_busy, o_done;
    logic [CW-1:0] o_step_count;

    step_sequencer #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
        .i_clk        (clk),
        .i_reset      (tb_reset),
        .i_start      (tb_start),
        .i_pause      (tb_pause),
        .i_single     (tb_single),
        .i_abort      (tb_abort),
        .i_stop       (tb_stop),
`ifdef STEP_SEQUENCER_TRIGGER_EN
        .i_trigger    (tb_trig),
`endif
        .i_period     (tb_period),
        .o_run        (o_run),
        .o_step       (o_step),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_step_count (o_step_count)
    );

    typedef struct packed {
        logic          run;
        logic          step;
        logic          busy;
        logic          done;
        logic [CW-1:0] count;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done_flag = 1'b0;

    // Reference model: steps are scheduled as absolute cycle numbers ("due"), pauses store the remaining distance.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE, M_ARMED} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_count = 0;
    int      m_p     = 0;
    longint  m_cyc   = 0;
    longint  m_due   = 0;
    longint  m_rem   = 0;
    bit      m_fresh = 1'b0;

    always @(posedge clk) begin
        bit   trig, step, eval;
        obs_t e;
        trig = tb_trig;
        step = 1'b0;
        eval = 1'b0;
        if (tb_reset) begin
            m_state = M_IDLE; m_count = 0; m_p = 0; m_fresh = 1'b0;
        end else if (tb_abort) begin
            m_state = M_IDLE; m_fresh = 1'b0;
        end else begin
            case (m_state)
                M_IDLE, M_DONE: if (tb_start) begin
                    m_p = int'(tb_period);
                    m_count = 0;
`ifdef STEP_SEQUENCER_TRIGGER_EN
                    m_state = M_ARMED;
`else
                    m_state = M_RUN; m_fresh = 1'b1; m_due = m_cyc + 1 + m_p; eval = 1'b1;
`endif
                end
                M_ARMED: if (trig) begin
                    m_state = M_RUN; m_fresh = 1'b1; m_due = m_cyc + 1 + m_p; eval = 1'b1;
                end
                M_RUN: begin
                    if (tb_stop && !m_fresh) m_state = M_DONE;
                    else if (tb_pause) begin m_state = M_PAUSE; m_rem = m_due - m_cyc; end
                    else eval = 1'b1;
                    m_fresh = 1'b0;
                end
                M_PAUSE: begin
                    if (tb_stop) m_state = M_DONE;
                    else if (tb_start) begin m_state = M_RUN; m_due = m_cyc + 1 + m_rem; end
                    else if (tb_single) step = 1'b1;
                end
                default: m_state = M_IDLE;
            endcase
        end
        if (eval && (m_cyc + 1 == m_due)) begin
            step  = 1'b1;
            m_due = m_due + m_p + 1;
        end
        if (step) m_count = (m_count == MAXC) ? MAXC : m_count + 1;
        e.run   = (m_state == M_RUN) || (m_state == M_PAUSE);
        e.busy  = (m_state == M_RUN) || (m_state == M_PAUSE) || (m_state == M_ARMED);
        e.done  = (m_state == M_DONE);
        e.step  = step;
        e.count = CW'(m_count);
        exp_q.push_back(e);
        m_cyc = m_cyc + 1;
    end

    // Monitor: compares each presented output vector against the oldest prediction.
    always @(negedge clk) begin
        obs_t got, e;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {o_run, o_step, o_busy, o_done, o_step_count};
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t run/step/busy/done/count got %b%b%b%b/%0d want %b%b%b%b/%0d",
                         $time, got.run, got.step, got.busy, got.done, got.count,
                         e.run, e.step, e.busy, e.done, e.count);
            end
        end
    end

    // Watchdog: the stimulus must reach the summary before the wait expires.
    initial begin
        #200000;
        n_cmp++;
        if (done_flag == 1'b0) begin
            n_err++;
            $display("FAIL timeout t=%0t: stimulus did not complete", $time);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
        tb_start = 1'b0; tb_pause = 1'b0; tb_single = 1'b0; tb_abort = 1'b0; tb_trig = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if ({o_run, o_step, o_busy, o_done} !== 4'b0000 || o_step_count !== CW'(0)) begin
            n_err++;
            $display("FAIL reset-state %s t=%0t run/step/busy/done/count %b%b%b%b/%0d",
                     tag, $time, o_run, o_step, o_busy, o_done, o_step_count);
        end
    endtask

    // Start a run; with the trigger stage, arm and fire the trigger 20 cycles later.
    task automatic launch(input int p);
        tb_period = PW'(p);
        tb_start  = 1'b1;
        tick(1);
`ifdef STEP_SEQUENCER_TRIGGER_EN
        tick(19);
        tb_trig = 1'b1;
        tick(1);
`endif
    endtask

    initial begin
        tick(3);
        check_idle("initial");
        tb_reset = 1'b0;
        tick(2);
        // Period 3: steps every fourth cycle; a new i_period mid-run is ignored.
        launch(3); tick(6);
        tb_period = PW'(7); tick(7);
        // Reset mid-run, then a normal start.
        tb_reset = 1'b1; tick(1);
        check_idle("mid-run");
        tb_reset = 1'b0; tick(1);
        launch(1); tick(6);
        tb_abort = 1'b1; tick(1); tick(1);
        // Period 0 for five cycles, pause, two single steps, start+single, abort in pause.
        launch(0); tick(4);
        tb_pause = 1'b1; tick(1); tick(3);
        tb_single = 1'b1; tick(1); tick(2);
        tb_single = 1'b1; tick(1); tick(2);
        tb_single = 1'b1; tb_start = 1'b1; tick(1); tick(3);
        tb_pause = 1'b1; tick(1); tick(2);
        tb_abort = 1'b1; tick(1); tick(2);
        // Period 2: stop on the cycle that would fire the first step.
        launch(2); tick(1);
        tb_stop = 1'b1; tick(1); tick(2);
        // Restart from DONE while stop is still high for the first run cycle.
        launch(2); tick(1);
        tb_stop = 1'b0; tick(8);
        // Counter saturation with period 0.
        tb_abort = 1'b1; tick(1);
        launch(0); tick(40);
        tb_stop = 1'b1; tick(1); tb_stop = 1'b0; tick(2);
        // Randomized pulses and stop level.
        for (int i = 0; i < 800; i++) begin
            tb_start  = ($urandom_range(0, 99) < 6);
            tb_pause  = ($urandom_range(0, 99) < 6);
            tb_single = ($urandom_range(0, 99) < 10);
            tb_abort  = ($urandom_range(0, 99) < 2);
            tb_trig   = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 5) tb_stop = ~tb_stop;
            tb_period = PW'($urandom_range(0, 5));
            tb_reset  = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        tb_reset = 1'b0;
        tick(3);
        @(negedge clk);
        #1;
        done_flag = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
